// File: rtl/control_pkg.sv
// Shared constants for the LMG control block: address map, CTRL bits,
// piece codes and move-word layout.
package control_pkg;

    localparam int A_CTRL     = 0;
    localparam int A_COUNT    = 1;
    localparam int BOARD_BASE = 2;
    localparam int BOARD_LAST = 9;
    localparam int MOVES_BASE = 16;
    localparam int MOVES_MAX  = 111;

    localparam int C_START  = 0;
    localparam int C_DONE   = 1;
    localparam int C_SIDE   = 2;
    localparam int C_EP_LO  = 5;
    localparam int C_EPNONE = 8;

    localparam logic [2:0] P_EMPTY  = 3'd0;
    localparam logic [2:0] P_PAWN   = 3'd1;
    localparam logic [2:0] P_KNIGHT = 3'd2;
    localparam logic [2:0] P_BISHOP = 3'd3;
    localparam logic [2:0] P_ROOK   = 3'd4;
    localparam logic [2:0] P_QUEEN  = 3'd5;
    localparam logic [2:0] P_KING   = 3'd6;
    localparam logic       COL_WHITE = 1'b0;
    localparam logic       COL_BLACK = 1'b1;

    localparam int M_FCOL  = 0;
    localparam int M_FROW  = 3;
    localparam int M_TCOL  = 6;
    localparam int M_TROW  = 9;
    localparam int M_PROMO = 12;
    localparam int M_EP    = 15;
    localparam logic [31:0] MOVE_TERM = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_EMIT, S_TERM, S_DONE
    } state_t;

    function automatic logic [31:0] move_word(
        input logic [2:0] fc, input logic [2:0] fr,
        input logic [2:0] tc, input logic [2:0] tr,
        input logic [2:0] pr, input logic ep);
        logic [31:0] w;
        w = '0;
        w[M_FCOL +: 3]  = fc;
        w[M_FROW +: 3]  = fr;
        w[M_TCOL +: 3]  = tc;
        w[M_TROW +: 3]  = tr;
        w[M_PROMO +: 3] = pr;
        w[M_EP]         = ep;
        return w;
    endfunction

endpackage

// File: rtl/control_ram.sv
// Dual-port word RAM: port A serves the host, port B takes engine writes.
module control_ram
    import control_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic [AW-1:0] i_a_addr,
    input  logic          i_a_we,
    input  logic          i_a_re,
    input  logic [DW-1:0] i_a_wdata,
    output logic [DW-1:0] o_a_rdata,
    input  logic [AW-1:0] i_b_addr,
    input  logic          i_b_we,
    input  logic [DW-1:0] i_b_wdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_a_q;

    // Host writes are blocked while the engine runs, so ports never collide.
    always_ff @(posedge clk) begin
        if (i_b_we)
            r_mem[i_b_addr] <= i_b_wdata;
        else if (i_a_we)
            r_mem[i_a_addr] <= i_a_wdata;
        if (i_a_re)
            r_a_q <= r_mem[i_a_addr];
    end

    assign o_a_rdata = r_a_q;

endmodule

// File: rtl/control.sv
// Avalon-MM slave holding the board, control word and move list; runs the
// pawn move generator on a START rising edge.
module control
    import control_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] slave_address,
    input  logic                  slave_read,
    input  logic                  slave_write,
    input  logic [DATA_WIDTH-1:0] slave_writedata,
    input  logic [3:0]            slave_byteenable,
    output logic [DATA_WIDTH-1:0] slave_readdata
);

    state_t      r_state;
    logic [8:0]  r_ctrl;
    logic [6:0]  r_count;
    logic [6:0]  r_cnt;
    logic [31:0] r_rows [8];
    logic [5:0]  r_sq;
    logic [4:0]  r_mask;
    logic [1:0]  r_pidx;
    logic        r_rd_sel;
    logic [DATA_WIDTH-1:0] r_rd_reg;

    logic w_unused_be;
    assign w_unused_be = ^slave_byteenable;

    logic w_busy, w_host_we;
    logic w_is_ctrl, w_is_cnt, w_is_row;
    logic [2:0] w_row_idx;
    logic [DATA_WIDTH-1:0] w_reg_val, w_ram_q;

    assign w_busy    = (r_state != S_IDLE);
    assign w_host_we = slave_write && !w_busy;
    assign w_is_ctrl = slave_address == ADDR_WIDTH'(A_CTRL);
    assign w_is_cnt  = slave_address == ADDR_WIDTH'(A_COUNT);
    assign w_is_row  = slave_address >= ADDR_WIDTH'(BOARD_BASE) &&
                       slave_address <= ADDR_WIDTH'(BOARD_LAST);
    assign w_row_idx = slave_address[2:0] - 3'd2;

    always_comb begin
        w_reg_val = '0;
        if (w_is_ctrl)
            w_reg_val = DATA_WIDTH'(r_ctrl);
        else if (w_is_cnt)
            w_reg_val = DATA_WIDTH'(r_count);
        else if (w_is_row)
            w_reg_val = r_rows[w_row_idx];
    end

    // Register reads come from flops; everything else from the RAM port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_sel <= 1'b1;
            r_rd_reg <= '0;
        end else if (slave_read) begin
            r_rd_sel <= w_is_ctrl || w_is_cnt || w_is_row;
            r_rd_reg <= w_reg_val;
        end
    end

    assign slave_readdata = r_rd_sel ? r_rd_reg : w_ram_q;

    logic       w_white, w_fwd_ok, w_dbl_row, w_is_pawn, w_ep_ok;
    logic [2:0] w_row, w_col, w_r1, w_r2, w_ep_col;
    logic [3:0] w_p0, w_p1, w_p2, w_pl, w_pr;
    logic [4:0] w_mask;

    assign w_row     = r_sq[5:3];
    assign w_col     = r_sq[2:0];
    assign w_white   = ~r_ctrl[C_SIDE];
    assign w_ep_col  = r_ctrl[C_EP_LO +: 3];
    assign w_r1      = w_white ? w_row + 3'd1 : w_row - 3'd1;
    assign w_r2      = w_white ? 3'd3 : 3'd4;
    assign w_fwd_ok  = w_white ? (w_row != 3'd7) : (w_row != 3'd0);
    assign w_dbl_row = w_white ? (w_row == 3'd1) : (w_row == 3'd6);
    assign w_p0 = r_rows[w_row][{w_col, 2'b00} +: 4];
    assign w_p1 = r_rows[w_r1][{w_col, 2'b00} +: 4];
    assign w_p2 = r_rows[w_r2][{w_col, 2'b00} +: 4];
    assign w_pl = r_rows[w_r1][{w_col - 3'd1, 2'b00} +: 4];
    assign w_pr = r_rows[w_r1][{w_col + 3'd1, 2'b00} +: 4];
    assign w_is_pawn = (w_p0[2:0] == P_PAWN) && (w_p0[3] == r_ctrl[C_SIDE]);
    assign w_ep_ok = !r_ctrl[C_EPNONE] &&
                     (w_row == (w_white ? 3'd4 : 3'd3)) &&
                     ((w_col != 3'd7 && w_col + 3'd1 == w_ep_col) ||
                      (w_col != 3'd0 && w_col - 3'd1 == w_ep_col));

    // Candidate moves for the current square, in emission order.
    assign w_mask[0] = w_is_pawn && w_fwd_ok && w_p1[2:0] == P_EMPTY;
    assign w_mask[1] = w_is_pawn && w_dbl_row && w_p1[2:0] == P_EMPTY &&
                       w_p2[2:0] == P_EMPTY;
    assign w_mask[2] = w_is_pawn && w_fwd_ok && w_col != 3'd0 &&
                       w_pl[2:0] != P_EMPTY && w_pl[3] != r_ctrl[C_SIDE];
    assign w_mask[3] = w_is_pawn && w_fwd_ok && w_col != 3'd7 &&
                       w_pr[2:0] != P_EMPTY && w_pr[3] != r_ctrl[C_SIDE];
    assign w_mask[4] = w_is_pawn && w_ep_ok;

    logic [4:0]  w_kind, w_rest;
    logic        w_promo, w_last;
    logic [2:0]  w_tc, w_tr, w_ptype;
    logic [31:0] w_move;

    assign w_kind  = r_mask & (~r_mask + 5'd1);
    assign w_rest  = r_mask & ~w_kind;
    assign w_promo = (w_r1 == (w_white ? 3'd7 : 3'd0)) &&
                     (w_kind[0] || w_kind[2] || w_kind[3]);
    assign w_last  = !w_promo || r_pidx == 2'd3;
    assign w_ptype = w_promo ? P_QUEEN - {1'b0, r_pidx} : P_EMPTY;

    always_comb begin
        w_tc = w_col;
        w_tr = w_r1;
        if (w_kind[1])
            w_tr = w_r2;
        else if (w_kind[2])
            w_tc = w_col - 3'd1;
        else if (w_kind[3])
            w_tc = w_col + 3'd1;
        else if (w_kind[4])
            w_tc = w_ep_col;
    end

    assign w_move = move_word(w_col, w_row, w_tc, w_tr, w_ptype, w_kind[4]);

    logic                  w_b_we;
    logic [ADDR_WIDTH-1:0] w_b_addr;
    logic [DATA_WIDTH-1:0] w_b_data;

    assign w_b_we   = (r_state == S_TERM) ||
                      (r_state == S_EMIT && r_cnt < 7'(MOVES_MAX));
    assign w_b_addr = ADDR_WIDTH'(MOVES_BASE) + ADDR_WIDTH'(r_cnt);
    assign w_b_data = (r_state == S_TERM) ? MOVE_TERM : w_move;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
            r_count <= '0;
            r_cnt   <= '0;
            r_rows  <= '{default: '0};
            r_sq    <= '0;
            r_mask  <= '0;
            r_pidx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_host_we) begin
                    if (w_is_ctrl) begin
                        r_ctrl[C_START] <= slave_writedata[C_START];
                        r_ctrl[8:2]     <= slave_writedata[8:2];
                        if (!slave_writedata[C_START])
                            r_ctrl[C_DONE] <= 1'b0;
                        if (slave_writedata[C_START] && !r_ctrl[C_START]) begin
                            r_ctrl[C_DONE] <= 1'b0;
                            r_state <= S_SCAN;
                            r_sq    <= '0;
                            r_cnt   <= '0;
                        end
                    end else if (w_is_row) begin
                        r_rows[w_row_idx] <= slave_writedata;
                    end
                end
                S_SCAN: begin
                    if (|w_mask) begin
                        r_mask  <= w_mask;
                        r_pidx  <= '0;
                        r_state <= S_EMIT;
                    end else if (r_sq == 6'd63) begin
                        r_state <= S_TERM;
                    end else begin
                        r_sq <= r_sq + 6'd1;
                    end
                end
                S_EMIT: begin
                    if (r_cnt < 7'(MOVES_MAX))
                        r_cnt <= r_cnt + 7'd1;
                    if (!w_last) begin
                        r_pidx <= r_pidx + 2'd1;
                    end else begin
                        r_pidx <= '0;
                        r_mask <= w_rest;
                        if (w_rest == '0) begin
                            if (r_sq == 6'd63) begin
                                r_state <= S_TERM;
                            end else begin
                                r_sq    <= r_sq + 6'd1;
                                r_state <= S_SCAN;
                            end
                        end
                    end
                end
                S_TERM: begin
                    r_count <= r_cnt;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_ctrl[C_DONE] <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    control_ram #(
        .AW(ADDR_WIDTH),
        .DW(DATA_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_a_addr  (slave_address),
        .i_a_we    (w_host_we),
        .i_a_re    (slave_read),
        .i_a_wdata (slave_writedata),
        .o_a_rdata (w_ram_q),
        .i_b_addr  (w_b_addr),
        .i_b_we    (w_b_we),
        .i_b_wdata (w_b_data)
    );

endmodule

// File: tb/tb_control.sv
// Directed self-checking bench for the control LMG slave.
module tb_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] slave_address = '0;
    logic        slave_read = 1'b0;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic [3:0]  slave_byteenable = 4'hF;
    logic [31:0] slave_readdata;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    control #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(13)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .slave_address    (slave_address),
        .slave_read       (slave_read),
        .slave_write      (slave_write),
        .slave_writedata  (slave_writedata),
        .slave_byteenable (slave_byteenable),
        .slave_readdata   (slave_readdata)
    );

    task automatic wr(input logic [12:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address = a;
        slave_writedata = d;
        slave_write = 1'b1;
        @(negedge clk);
        slave_write = 1'b0;
    endtask

    task automatic rd(input logic [12:0] a, output logic [31:0] d);
        @(negedge clk);
        slave_address = a;
        slave_read = 1'b1;
        repeat (3) @(negedge clk);
        d = slave_readdata;
        slave_read = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        logic [31:0] v;
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            rd(13'd0, v);
            if (v[1]) ok = 1'b1;
        end
    endtask

    task automatic run(input logic [31:0] ctrl, input string nm);
        bit ok;
        wr(13'd0, 32'h0);
        wr(13'd0, ctrl);
        wait_done(ok);
        total++;
        if (!ok) begin
            $display("FAIL %s done: DONE never set", nm);
            bad++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        @(negedge clk);
        total++;
        if (slave_readdata !== 32'h0) begin
            $display("FAIL rst_rdata got %h want 0", slave_readdata);
            bad++;
        end
        rd(13'd1, v);
        total++;
        if (v !== 32'h0) begin
            $display("FAIL rst_count got %h want 0", v);
            bad++;
        end
        for (int a = 0; a < 10; a++) wr(13'(a), 32'h0);
        for (int a = 2; a < 10; a++) begin
            rd(13'(a), v);
            total++;
            if (v !== 32'h0) begin
                $display("FAIL row%0d got %h want 0", a, v);
                bad++;
            end
        end
        rd(13'd0, v);
        total++;
        if (v !== 32'h0) begin
            $display("FAIL rst_ctrl got %h want 0", v);
            bad++;
        end
    endtask

    task automatic test_ep;
        logic [31:0] v;
        logic [31:0] exp [5];
        logic [12:0] adr [5];
        wr(13'd6, 32'h0000_1900);
        wr(13'd0, 32'h040);
        wr(13'd0, 32'h041);
        begin
            bit ok;
            wait_done(ok);
            total++;
            if (!ok) begin
                $display("FAIL ep done: DONE never set");
                bad++;
            end
        end
        adr = '{13'd0, 13'd1, 13'd16, 13'd17, 13'd18};
        exp = '{32'h043, 32'd2, 32'h0AE3, 32'h8AA3, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            rd(adr[i], v);
            total++;
            if (v !== exp[i]) begin
                $display("FAIL ep addr%0d got %h want %h", adr[i], v, exp[i]);
                bad++;
            end
        end
    endtask

    task automatic test_restart;
        logic [31:0] v;
        bit ok;
        wr(13'd0, 32'h002);
        rd(13'd0, v);
        total++;
        if (v !== 32'h0) begin
            $display("FAIL clr_done got %h want 0", v);
            bad++;
        end
        wr(13'd16, 32'h0);
        wr(13'd0, 32'h001);
        wait_done(ok);
        total++;
        if (!ok) begin
            $display("FAIL rerun done: DONE never set");
            bad++;
        end
        rd(13'd0, v);
        total++;
        if (v !== 32'h003) begin
            $display("FAIL rerun ctrl got %h want 003", v);
            bad++;
        end
        rd(13'd1, v);
        total++;
        if (v !== 32'd1) begin
            $display("FAIL rerun count got %0d want 1", v);
            bad++;
        end
        rd(13'd16, v);
        total++;
        if (v !== 32'h0AE3) begin
            $display("FAIL rerun mv0 got %h want 0ae3", v);
            bad++;
        end
        rd(13'd17, v);
        total++;
        if (v !== 32'hFFFF_FFFF) begin
            $display("FAIL rerun term got %h want ffffffff", v);
            bad++;
        end
    endtask

    task automatic test_double;
        logic [31:0] v;
        logic [31:0] exp [5];
        logic [12:0] adr [5];
        wr(13'd6, 32'h0);
        wr(13'd3, 32'h1111_1111);
        run(32'h101, "dbl");
        adr = '{13'd1, 13'd16, 13'd17, 13'd31, 13'd32};
        exp = '{32'd16, 32'h0408, 32'h0608, 32'h07CF, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            rd(adr[i], v);
            total++;
            if (v !== exp[i]) begin
                $display("FAIL dbl addr%0d got %h want %h", adr[i], v, exp[i]);
                bad++;
            end
        end
    endtask

    task automatic test_promo;
        logic [31:0] v;
        logic [31:0] exp [6];
        wr(13'd3, 32'h0);
        wr(13'd8, 32'h1);
        run(32'h101, "promo");
        exp = '{32'd4, 32'h5E30, 32'h4E30, 32'h3E30, 32'h2E30, 32'hFFFF_FFFF};
        rd(13'd1, v);
        total++;
        if (v !== exp[0]) begin
            $display("FAIL promo count got %0d want %0d", v, exp[0]);
            bad++;
        end
        for (int i = 1; i < 6; i++) begin
            rd(13'(15 + i), v);
            total++;
            if (v !== exp[i]) begin
                $display("FAIL promo addr%0d got %h want %h", 15 + i, v, exp[i]);
                bad++;
            end
        end
    endtask

    task automatic test_black;
        logic [31:0] v;
        logic [31:0] exp [7];
        logic [12:0] adr [7];
        wr(13'd8, 32'h0009_0000);
        wr(13'd7, 32'h0020_1000);
        run(32'h105, "black");
        adr = '{13'd0, 13'd1, 13'd16, 13'd17, 13'd18, 13'd19, 13'd20};
        exp = '{32'h107, 32'd4, 32'h0B34, 32'h0934, 32'h0AF4, 32'h0B74,
                32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            rd(adr[i], v);
            total++;
            if (v !== exp[i]) begin
                $display("FAIL black addr%0d got %h want %h", adr[i], v, exp[i]);
                bad++;
            end
        end
    endtask

    task automatic test_busy;
        logic [31:0] v;
        bit ok;
        wr(13'd0, 32'h0);
        wr(13'd0, 32'h105);
        wr(13'd16, 32'h0000_DEAD);
        wr(13'd0, 32'h0);
        wait_done(ok);
        total++;
        if (!ok) begin
            $display("FAIL busy done: DONE never set");
            bad++;
        end
        rd(13'd16, v);
        total++;
        if (v !== 32'h0B34) begin
            $display("FAIL busy mv0 got %h want 0b34", v);
            bad++;
        end
        rd(13'd0, v);
        total++;
        if (v !== 32'h107) begin
            $display("FAIL busy ctrl got %h want 107", v);
            bad++;
        end
        wr(13'd200, 32'h1234);
        rd(13'd200, v);
        total++;
        if (v !== 32'h1234) begin
            $display("FAIL ram200 got %h want 1234", v);
            bad++;
        end
        wr(13'd10, 32'hCAFE_F00D);
        rd(13'd10, v);
        total++;
        if (v !== 32'hCAFE_F00D) begin
            $display("FAIL ram10 got %h want cafef00d", v);
            bad++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_ep();
        test_restart();
        test_double();
        test_promo();
        test_black();
        test_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
